// File: rtl/stream_delay_fifo.sv
// rtl/stream_delay_fifo.sv - valid-gated programmable delay line over a circular buffer
// Optional zero-fill of unprimed outputs: STREAM_DELAY_FIFO_ZERO_FILL_EN
module stream_delay_fifo #(
  parameter int WIDTH         = 8,
  parameter int MAX_DELAY     = 64,
  parameter int DEFAULT_DELAY = 10,
  localparam int DW           = $clog2(MAX_DELAY + 1),
  localparam int AW           = $clog2(MAX_DELAY)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  input  logic [DW-1:0]    delay_cfg,
  input  logic             cfg_load,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic             primed,
  output logic [DW-1:0]    delay_active
);

  localparam logic [DW:0]   MAX_X   = (DW + 1)'(MAX_DELAY);
  localparam logic [DW-1:0] MAX_D   = DW'(MAX_DELAY);
  localparam logic [AW-1:0] LAST_WA = AW'(MAX_DELAY - 1);

  logic [WIDTH-1:0] mem [MAX_DELAY];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [DW-1:0]    fill_q, fill_d;
  logic [DW-1:0]    delay_q, delay_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             valid_out_q, valid_out_d;

  logic [AW-1:0]    wr_ptr_inc;
  logic [DW:0]      rd_sum;
  logic [DW:0]      rd_wrap;
  logic [AW-1:0]    rd_addr;
  logic [DW-1:0]    cfg_clamped;
  logic             primed_w;

  // Read address is wr_ptr - delay modulo depth; depth need not be a power of two.
  always_comb begin
    rd_sum     = (DW + 1)'(wr_ptr_q) + MAX_X - {1'b0, delay_q};
    rd_wrap    = (rd_sum >= MAX_X) ? (rd_sum - MAX_X) : rd_sum;
    rd_addr    = rd_wrap[AW-1:0];
    wr_ptr_inc = (wr_ptr_q == LAST_WA) ? '0 : (wr_ptr_q + AW'(1));
    primed_w   = (fill_q >= delay_q);
    if (delay_cfg == '0) begin
      cfg_clamped = DW'(1);
    end else if (delay_cfg > MAX_D) begin
      cfg_clamped = MAX_D;
    end else begin
      cfg_clamped = delay_cfg;
    end
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    fill_d      = fill_q;
    delay_d     = delay_q;
    data_out_d  = data_out_q;
    valid_out_d = 1'b0;
    if (cfg_load) begin
      delay_d = cfg_clamped;
      fill_d  = valid_in ? DW'(1) : '0;
      if (valid_in) begin
        wr_ptr_d = wr_ptr_inc;
`ifdef STREAM_DELAY_FIFO_ZERO_FILL_EN
        valid_out_d = 1'b1;
        data_out_d  = '0;
`endif
      end
    end else if (valid_in) begin
      wr_ptr_d = wr_ptr_inc;
      fill_d   = (fill_q == MAX_D) ? fill_q : (fill_q + DW'(1));
      if (primed_w) begin
        valid_out_d = 1'b1;
        data_out_d  = mem[rd_addr];
      end else begin
`ifdef STREAM_DELAY_FIFO_ZERO_FILL_EN
        valid_out_d = 1'b1;
        data_out_d  = '0;
`else
        valid_out_d = 1'b0;
`endif
      end
    end
  end

  // Storage is not reset; the old entry is read in the same cycle it is overwritten.
  always_ff @(posedge clk) begin
    if (valid_in && !rst) begin
      mem[wr_ptr_q] <= data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      fill_q      <= '0;
      delay_q     <= DW'(DEFAULT_DELAY);
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      fill_q      <= fill_d;
      delay_q     <= delay_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
    end
  end

  assign data_out     = data_out_q;
  assign valid_out    = valid_out_q;
  assign primed       = primed_w;
  assign delay_active = delay_q;

endmodule

// File: tb/tb_stream_delay_fifo.sv
// tb/tb_stream_delay_fifo.sv - scoreboard bench for stream_delay_fifo (depth 64 and depth 6)
module tb_stream_delay_fifo;

  localparam int W   = 8;
  localparam int MA  = 64;
  localparam int MB  = 6;
  localparam int DWA = $clog2(MA + 1);
  localparam int DWB = $clog2(MB + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [W-1:0]   a_din = '0;
  logic           a_vin = 1'b0;
  logic [DWA-1:0] a_cfg = '0;
  logic           a_load = 1'b0;
  logic [W-1:0]   a_dout;
  logic           a_vout;
  logic           a_primed;
  logic [DWA-1:0] a_dact;

  logic [W-1:0]   b_din = '0;
  logic           b_vin = 1'b0;
  logic [DWB-1:0] b_cfg = '0;
  logic           b_load = 1'b0;
  logic [W-1:0]   b_dout;
  logic           b_vout;
  logic           b_primed;
  logic [DWB-1:0] b_dact;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] a_q[$];
  logic [W-1:0] b_q[$];

  always #5 clk = ~clk;

  stream_delay_fifo #(.WIDTH(W), .MAX_DELAY(MA), .DEFAULT_DELAY(10)) dut_a (
    .clk(clk), .rst(rst), .data_in(a_din), .valid_in(a_vin), .delay_cfg(a_cfg),
    .cfg_load(a_load), .data_out(a_dout), .valid_out(a_vout), .primed(a_primed),
    .delay_active(a_dact)
  );

  stream_delay_fifo #(.WIDTH(W), .MAX_DELAY(MB), .DEFAULT_DELAY(MB)) dut_b (
    .clk(clk), .rst(rst), .data_in(b_din), .valid_in(b_vin), .delay_cfg(b_cfg),
    .cfg_load(b_load), .data_out(b_dout), .valid_out(b_vout), .primed(b_primed),
    .delay_active(b_dact)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (a_vout) begin
      if (a_q.size() == 0) chk("a_unexpected_valid", a_vout, 0);
      else chk("a_data", a_dout, a_q.pop_front());
    end
  end

  always @(negedge clk) begin
    if (b_vout) begin
      if (b_q.size() == 0) chk("b_unexpected_valid", b_vout, 0);
      else chk("b_data", b_dout, b_q.pop_front());
    end
  end

  task automatic a_acc(input logic [W-1:0] d, input bit ev, input logic [W-1:0] ed);
    a_din = d;
    a_vin = 1'b1;
    if (ev) a_q.push_back(ed);
`ifdef STREAM_DELAY_FIFO_ZERO_FILL_EN
    else a_q.push_back('0);
`endif
    @(posedge clk); #1;
    a_vin = 1'b0;
  endtask

  task automatic b_acc(input logic [W-1:0] d, input bit ev, input logic [W-1:0] ed);
    b_din = d;
    b_vin = 1'b1;
    if (ev) b_q.push_back(ed);
`ifdef STREAM_DELAY_FIFO_ZERO_FILL_EN
    else b_q.push_back('0);
`endif
    @(posedge clk); #1;
    b_vin = 1'b0;
  endtask

  task automatic a_cfg_load(input int d, input bit with_valid, input logic [W-1:0] din);
    a_cfg  = DWA'(d);
    a_load = 1'b1;
    a_vin  = with_valid;
    a_din  = din;
`ifdef STREAM_DELAY_FIFO_ZERO_FILL_EN
    if (with_valid) a_q.push_back('0);
`endif
    @(posedge clk); #1;
    a_load = 1'b0;
    a_vin  = 1'b0;
  endtask

  task automatic b_cfg_load(input int d);
    b_cfg  = DWB'(d);
    b_load = 1'b1;
    @(posedge clk); #1;
    b_load = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    idle(2);
    rst = 1'b0;
    chk("rst_valid_out", a_vout, 0);
    chk("rst_data_out", a_dout, 0);
    chk("rst_primed", a_primed, 0);
    chk("rst_delay_active", a_dact, 10);
    chk("rst_b_delay_active", b_dact, MB);

    // back-to-back with D=3
    a_cfg_load(3, 1'b0, '0);
    chk("cfg3_delay_active", a_dact, 3);
    chk("cfg3_primed", a_primed, 0);
    a_acc(1, 1'b0, 0);
    a_acc(2, 1'b0, 0);
    a_acc(3, 1'b0, 0);
    chk("d3_primed_after_3", a_primed, 1);
    a_acc(4, 1'b1, 1);
    a_acc(5, 1'b1, 2);
    a_acc(6, 1'b1, 3);
    idle(1);
    chk("d3_hold_data", a_dout, 3);
    chk("d3_idle_valid", a_vout, 0);

    // D=3 with bubbles
    a_cfg_load(3, 1'b0, '0);
    chk("flush_primed", a_primed, 0);
    a_acc(10, 1'b0, 0); idle(1);
    a_acc(20, 1'b0, 0); idle(1);
    a_acc(30, 1'b0, 0); idle(1);
    a_acc(40, 1'b1, 10); idle(1);
    chk("bubble_hold_data", a_dout, 10);
    chk("bubble_valid_low", a_vout, 0);
    a_acc(50, 1'b1, 20); idle(1);
    chk("bubble_hold_data2", a_dout, 20);

    // clamping and D=MAX across pointer wrap
    a_cfg_load(0, 1'b0, '0);
    chk("clamp_low", a_dact, 1);
    a_acc(7, 1'b0, 0);
    a_acc(8, 1'b1, 7);
    a_cfg_load(200, 1'b0, '0);
    chk("clamp_high", a_dact, MA);
    chk("clamp_high_primed", a_primed, 0);
    for (int k = 0; k < MA + 16; k++) a_acc(W'(k), k >= MA, W'(k - MA));
    chk("dmax_primed", a_primed, 1);

    // reconfigure together with a valid sample
    a_cfg_load(4, 1'b0, '0);
    for (int k = 1; k <= 4; k++) a_acc(W'(k), 1'b0, 0);
    a_acc(5, 1'b1, 1);
    a_acc(6, 1'b1, 2);
    a_cfg_load(2, 1'b1, 99);
    chk("cfgv_delay_active", a_dact, 2);
    chk("cfgv_primed", a_primed, 0);
`ifndef STREAM_DELAY_FIFO_ZERO_FILL_EN
    chk("cfgv_valid_out", a_vout, 0);
`endif
    a_acc(100, 1'b0, 0);
    a_acc(101, 1'b1, 99);
    chk("cfgv_primed_after", a_primed, 1);

    // asynchronous reset while an output is valid
    a_din = 102;
    a_vin = 1'b1;
    @(posedge clk); #1;
    a_vin = 1'b0;
    chk("pre_rst_valid", a_vout, 1);
    chk("pre_rst_data", a_dout, 100);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_valid", a_vout, 0);
    chk("async_rst_data", a_dout, 0);
    chk("async_rst_primed", a_primed, 0);
    chk("async_rst_delay", a_dact, 10);
    @(posedge clk); #1;
    rst = 1'b0;

    // depth 6 (not a power of two), D=MAX then D=5
    for (int k = 0; k < 20; k++) b_acc(W'(k), k >= MB, W'(k - MB));
    chk("b_primed", b_primed, 1);
    b_cfg_load(5);
    chk("b_delay_active", b_dact, 5);
    for (int k = 0; k < 10; k++) b_acc(W'(30 + k), k >= 5, W'(30 + k - 5));

    idle(3);
    chk("a_queue_drained", a_q.size(), 0);
    chk("b_queue_drained", b_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
